// File: rtl/sw_select_ctrl_n.sv
// sw_select_ctrl_n: merges debounced physical switches and UART byte
// commands into one registered switch vector, and reports that vector
// over the UART TX interface as ASCII hex digits followed by CR.
//
// TX handshake: o_tx_start is a one-cycle strobe, raised only after the
// report FSM saw tx_busy low; o_tx_data is registered together with the
// strobe and holds until the next strobe. The UART raises tx_busy a cycle
// after the strobe, so the first WAIT cycle does not look at tx_busy.
module sw_select_ctrl_n #(
   parameter int NUM_SW          = 8,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int AUTO_REPORT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_SW-1:0] i_sw,
   input  logic              rx_done,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              o_tx_start,
   output logic [7:0]        o_tx_data,
   output logic [NUM_SW-1:0] o_sw,
   output logic              o_reset,
   output logic              o_sw_changed
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int NDIG   = (NUM_SW + 3) / 4;
   localparam int SNAP_W = 4 * NDIG;
   localparam int IDX_W  = $clog2(NDIG + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;

   // debouncer state
   logic [NUM_SW-1:0] sync1_q, sync2_q, stable_q, stable_d, phys_edge;
   logic [CNT_W-1:0]  cnt_q [NUM_SW];
   logic [CNT_W-1:0]  cnt_d [NUM_SW];

   // switch vector and pulses
   logic [NUM_SW-1:0] sw_q, sw_d;
   logic              changed_q, changed_d;
   logic              reset_q;

   // report FSM
   state_t            state_q, state_d;
   logic              pend_q, pend_d;
   logic              first_q, first_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SNAP_W-1:0] snap_q, snap_d;
   logic              start_q, start_d;
   logic [7:0]        data_q, data_d;
   logic [3:0]        nib;
   logic [7:0]        tx_byte;

   // command decode, valid only in the rx_done cycle
   logic cmd_esc, cmd_all, cmd_clr, cmd_qry, cmd_dig, req;
   assign cmd_esc = rx_done && (rx_data == 8'h1B);
   assign cmd_all = rx_done && (rx_data == 8'h41);
   assign cmd_clr = rx_done && (rx_data == 8'h5A);
   assign cmd_qry = rx_done && (rx_data == 8'h3F);
   assign cmd_dig = rx_done && (rx_data >= 8'h30) && (rx_data <= 8'h39);

   // the ESC-induced clear is not a reportable change
   assign req = cmd_qry || ((AUTO_REPORT != 0) && changed_q && !reset_q);

   // debounce counters: count disagreement cycles, commit at the limit
   always_comb begin
      stable_d  = stable_q;
      phys_edge = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i]  = sync2_q[i];
               phys_edge[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // debouncer registers; reset adopts the current switch levels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= i_sw;
         sync2_q  <= i_sw;
         stable_q <= i_sw;
         for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q  <= i_sw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // next switch vector: UART effect, then physical edges, then ESC
   always_comb begin
      sw_d = sw_q;
      if (cmd_dig) begin
         for (int i = 0; i < NUM_SW; i++)
            if (int'(rx_data[3:0]) == i) sw_d[i] = ~sw_q[i];
      end else if (cmd_all) begin
         sw_d = '1;
      end else if (cmd_clr) begin
         sw_d = '0;
      end
      sw_d = (sw_d & ~phys_edge) | (stable_d & phys_edge);
      if (cmd_esc) sw_d = '0;
      changed_d = (sw_d != sw_q);
   end

   // switch vector and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_q      <= '0;
         changed_q <= 1'b0;
         reset_q   <= 1'b0;
      end else begin
         sw_q      <= sw_d;
         changed_q <= changed_d;
         reset_q   <= cmd_esc;
      end
   end

   // current report byte: hex digit of the snapshot, MS first, then CR
   always_comb begin
      nib     = 4'h0;
      tx_byte = 8'h0D;
      if (idx_q != LAST_IDX) begin
         nib     = 4'(snap_q >> (4 * (NDIG - 1 - int'(idx_q))));
         tx_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      end
   end

   // report FSM next state
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      first_d = 1'b0;
      start_d = 1'b0;
      data_d  = data_q;
      if (req && (state_q != S_IDLE)) pend_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (req || pend_q) begin
               pend_d  = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            snap_d  = SNAP_W'(sw_q);
            idx_d   = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (!tx_busy) begin
               data_d  = tx_byte;
               start_d = 1'b1;
               first_d = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!first_q && !tx_busy) begin
               if (idx_q != LAST_IDX) begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_SEND;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (cmd_esc) begin
         state_d = S_IDLE;
         pend_d  = 1'b0;
         start_d = 1'b0;
      end
   end

   // report FSM registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pend_q  <= 1'b0;
         first_q <= 1'b0;
         idx_q   <= '0;
         snap_q  <= '0;
         start_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         first_q <= first_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         start_q <= start_d;
         data_q  <= data_d;
      end
   end

   assign o_sw         = sw_q;
   assign o_sw_changed = changed_q;
   assign o_reset      = reset_q;
   assign o_tx_start   = start_q;
   assign o_tx_data    = data_q;

endmodule

// File: tb/tb_sw_select_ctrl_n.sv
// Bench for sw_select_ctrl_n (NUM_SW=8, DEBOUNCE_CYCLES=4, AUTO_REPORT=1).
// A UART TX model stays busy 5 cycles per byte and checks every sent byte
// against the expected-byte queue.
module tb_sw_select_ctrl_n;

   localparam int NUM_SW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_SW-1:0] i_sw;
   logic              rx_done;
   logic [7:0]        rx_data;
   logic              tx_busy;
   logic              o_tx_start;
   logic [7:0]        o_tx_data;
   logic [NUM_SW-1:0] o_sw;
   logic              o_reset;
   logic              o_sw_changed;

   int n_checks = 0;
   int n_fail   = 0;
   int chg_cnt  = 0;
   int busy_cnt = 0;
   logic [7:0] exp_q[$];

   sw_select_ctrl_n #(
      .NUM_SW(NUM_SW), .DEBOUNCE_CYCLES(4), .AUTO_REPORT(1)
   ) dut (
      .clk(clk), .rst(rst), .i_sw(i_sw), .rx_done(rx_done), .rx_data(rx_data),
      .tx_busy(tx_busy), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
      .o_sw(o_sw), .o_reset(o_reset), .o_sw_changed(o_sw_changed)
   );

   // clock
   always #5 clk = ~clk;

   assign tx_busy = (busy_cnt != 0);

   // UART TX model and byte scoreboard
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
      end else if (o_tx_start) begin
         n_checks++;
         if (tx_busy) begin
            n_fail++;
            $display("FAIL start_while_busy: tx_start=1 with tx_busy=%0b, required tx_busy=0", tx_busy);
         end
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_byte: got unexpected byte %02h, required no byte", o_tx_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (o_tx_data !== e) begin
               n_fail++;
               $display("FAIL tx_byte: got %02h required %02h", o_tx_data, e);
            end
         end
         busy_cnt = 5;
      end else if (busy_cnt != 0) begin
         busy_cnt = busy_cnt - 1;
      end
   end

   // change-pulse counter
   always @(negedge clk) if (!rst && o_sw_changed) chg_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] hex_ch(input logic [3:0] n);
      string s = "0123456789ABCDEF";
      return s[n];
   endfunction

   // reference: effect of one command byte on the switch vector
   function automatic logic [7:0] model_cmd(input logic [7:0] sw, input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39) begin
         int k = int'(b) - 48;
         if (k < NUM_SW) sw[k] = ~sw[k];
      end else if (b == 8'h41) sw = 8'hFF;
      else if (b == 8'h5A || b == 8'h1B) sw = 8'h00;
      return sw;
   endfunction

   task automatic push_frame(input logic [7:0] v);
      exp_q.push_back(hex_ch(v[7:4]));
      exp_q.push_back(hex_ch(v[3:0]));
      exp_q.push_back(8'h0D);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic wait_quiet();
      int q = 0;
      int t = 0;
      while (q < 12 && t < 400) begin
         @(negedge clk);
         t++;
         if (!o_tx_start && !tx_busy) q++;
         else q = 0;
      end
      check("tx_quiet_timeout", (q >= 12), 1);
   endtask

   typedef struct {
      logic [7:0] rx;
      logic [7:0] sw;
      logic       chg;
   } vec_t;

   vec_t vecs[11];
   logic [7:0] cmds[16];

   initial begin
      int lat;
      int lat_use;
      int c0;
      bit seen;
      logic [7:0] exp_sw, prev, b;
      int ch;

      vecs[0]  = '{8'h33, 8'h08, 1'b1};
      vecs[1]  = '{8'h33, 8'h00, 1'b1};
      vecs[2]  = '{8'h39, 8'h00, 1'b0};
      vecs[3]  = '{8'h41, 8'hFF, 1'b1};
      vecs[4]  = '{8'h41, 8'hFF, 1'b0};
      vecs[5]  = '{8'h5A, 8'h00, 1'b1};
      vecs[6]  = '{8'h30, 8'h01, 1'b1};
      vecs[7]  = '{8'h37, 8'h81, 1'b1};
      vecs[8]  = '{8'h78, 8'h81, 1'b0};
      vecs[9]  = '{8'h3F, 8'h81, 1'b0};
      vecs[10] = '{8'h5A, 8'h00, 1'b1};
      cmds = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
               8'h38, 8'h39, 8'h41, 8'h5A, 8'h3F, 8'h1B, 8'h42, 8'h7A};

      // reset with switches 0 and 7 held high
      rst = 1'b1; i_sw = 8'h81; rx_done = 1'b0; rx_data = 8'h00;
      cycles(3);
      check("rst_o_sw", o_sw, 0);
      check("rst_o_reset", o_reset, 0);
      check("rst_o_tx_start", o_tx_start, 0);
      check("rst_o_tx_data", o_tx_data, 0);
      check("rst_o_sw_changed", o_sw_changed, 0);
      rst = 1'b0;
      cycles(20);
      check("post_rst_o_sw", o_sw, 0);
      check("post_rst_no_change", chg_cnt, 0);

      // held switches released: stable falls but o_sw already 0
      i_sw = 8'h00;
      cycles(12);
      check("release_o_sw", o_sw, 0);
      check("release_no_change", chg_cnt, 0);

      // debounced rise on channel 3
      push_frame(8'h08);
      i_sw[3] = 1'b1;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (lat == 0 && o_sw[3]) lat = k;
      end
      check("deb_latency_in_range", (lat >= 3 && lat <= 7), 1);
      check("deb_rise_o_sw", o_sw, 8'h08);
      wait_quiet();

      // 3-cycle glitch on channel 5 is filtered
      i_sw[5] = 1'b1;
      cycles(3);
      i_sw[5] = 1'b0;
      cycles(12);
      check("glitch_o_sw", o_sw, 8'h08);
      check("glitch_change_count", chg_cnt, 1);

      i_sw[3] = 1'b0;
      push_frame(8'h00);
      cycles(12);
      check("deb_fall_o_sw", o_sw, 8'h00);
      wait_quiet();

      // command table
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].chg || vecs[i].rx == 8'h3F) push_frame(vecs[i].sw);
         send_rx(vecs[i].rx);
         check("vec_o_sw", o_sw, vecs[i].sw);
         check("vec_o_sw_changed", o_sw_changed, vecs[i].chg);
         wait_quiet();
      end

      // two '?' and a 'Z' during a frame: one extra frame with fresh value
      push_frame(8'hFF);
      send_rx(8'h41);
      cycles(5);
      send_rx(8'h3F);
      cycles(2);
      send_rx(8'h5A);
      check("coalesce_z_o_sw", o_sw, 8'h00);
      push_frame(8'h00);
      cycles(2);
      send_rx(8'h3F);
      wait_quiet();
      check("coalesce_frames_drained", exp_q.size(), 0);

      // physical edge and UART toggle on the same bit, same cycle
      push_frame(8'h02);
      send_rx(8'h31);
      check("pre_same_cycle_o_sw", o_sw, 8'h02);
      wait_quiet();
      lat_use = (lat >= 1 && lat <= 12) ? lat : 6;
      i_sw[1] = 1'b1;
      if (lat_use > 1) cycles(lat_use - 1);
      send_rx(8'h31);
      check("phys_wins_o_sw", o_sw, 8'h02);
      check("phys_wins_no_change", o_sw_changed, 0);
      cycles(12);
      check("phys_wins_hold", o_sw, 8'h02);
      wait_quiet();

      // ESC in the middle of a frame
      exp_q.push_back(8'h30);
      send_rx(8'h3F);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (o_tx_start) seen = 1'b1;
      end
      check("esc_frame_started", seen, 1);
      send_rx(8'h1B);
      check("esc_o_reset_high", o_reset, 1);
      check("esc_o_sw", o_sw, 8'h00);
      @(negedge clk);
      check("esc_o_reset_one_cycle", o_reset, 0);
      cycles(40);
      check("esc_no_more_bytes", exp_q.size(), 0);

      // randomized mix against the reference model
      exp_sw = 8'h00;
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 9) < 7) begin
            b = cmds[$urandom_range(0, 15)];
            prev = exp_sw;
            exp_sw = model_cmd(prev, b);
            if (b != 8'h1B && (exp_sw != prev || b == 8'h3F)) push_frame(exp_sw);
            send_rx(b);
            check("rnd_cmd_o_sw", o_sw, exp_sw);
            check("rnd_cmd_changed", o_sw_changed, (exp_sw != prev));
            if (b == 8'h1B) check("rnd_esc_o_reset", o_reset, 1);
         end else begin
            ch = $urandom_range(0, NUM_SW - 1);
            i_sw[ch] = ~i_sw[ch];
            prev = exp_sw;
            exp_sw[ch] = i_sw[ch];
            c0 = chg_cnt;
            if (exp_sw != prev) push_frame(exp_sw);
            cycles(12);
            check("rnd_phys_o_sw", o_sw, exp_sw);
            check("rnd_phys_changes", chg_cnt - c0, (exp_sw != prev) ? 1 : 0);
         end
         wait_quiet();
      end

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
